dmem_responder: RTL and testbench

Data-memory responder for the single-cycle MIPS core. It sits on the far side of the core's data-memory port and answers the core's CEN/WEN/OEN/A/write-data requests. It holds 2^ADDR_W words, serves combinational reads, and commits synchronous writes. It also provides a backdoor preload port, access counters, and a sticky protocol-error monitor for the verification bench.

---
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle MIPS core: combinational reads,
// synchronous writes, backdoor preload, saturating access counters and a sticky error monitor.
module dmem_responder #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q,
  input  logic              LD_EN,
  input  logic [ADDR_W-1:0] LD_A,
  input  logic [DATA_W-1:0] LD_D,
  input  logic              CLR,
  output logic [CNT_W-1:0]  RD_CNT,
  output logic [CNT_W-1:0]  WR_CNT,
  output logic              ERR,
  output logic [1:0]        ERR_CODE
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_CONFLICT = 2'b01;
  localparam logic [1:0] CODE_STRAY    = 2'b10;

  typedef enum logic {ST_OK, ST_FAULT} err_state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  err_state_t        err_state;

  logic acc_rd_c, acc_wr_c, acc_conflict_c, acc_stray_c;

  // Request decode; read and write are mutually exclusive by construction.
  always_comb begin
    acc_rd_c       = !CEN && !OEN &&  WEN;
    acc_wr_c       = !CEN && !WEN &&  OEN;
    acc_conflict_c = !CEN && !WEN && !OEN;
    acc_stray_c    =  CEN && (!WEN || !OEN);
  end

  // Zero-latency read port; drives zero whenever no legal read is decoded.
  always_comb begin
    Q = '0;
    if (acc_rd_c) begin
      Q = mem[A];
    end
  end

  // Storage: preload is applied after the functional write so it wins on an address match.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= '0;
      end
    end else begin
      if (acc_wr_c) begin
        mem[A] <= D;
      end
      if (LD_EN) begin
        mem[LD_A] <= LD_D;
      end
    end
  end

  // Saturating access counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RD_CNT <= '0;
      WR_CNT <= '0;
    end else if (CLR) begin
      RD_CNT <= '0;
      WR_CNT <= '0;
    end else begin
      if (acc_rd_c && (RD_CNT != CNT_MAX)) begin
        RD_CNT <= RD_CNT + CNT_W'(1);
      end
      if (acc_wr_c && (WR_CNT != CNT_MAX)) begin
        WR_CNT <= WR_CNT + CNT_W'(1);
      end
    end
  end

  // Sticky protocol-error monitor; only the first cause is recorded.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_state <= ST_OK;
      ERR_CODE  <= CODE_NONE;
    end else if (CLR) begin
      err_state <= ST_OK;
      ERR_CODE  <= CODE_NONE;
    end else begin
      case (err_state)
        ST_OK: begin
          if (acc_conflict_c) begin
            err_state <= ST_FAULT;
            ERR_CODE  <= CODE_CONFLICT;
          end else if (acc_stray_c) begin
            err_state <= ST_FAULT;
            ERR_CODE  <= CODE_STRAY;
          end
        end
        ST_FAULT: begin
          err_state <= ST_FAULT;
        end
        default: begin
          err_state <= ST_OK;
          ERR_CODE  <= CODE_NONE;
        end
      endcase
    end
  end

  assign ERR = (err_state == ST_FAULT);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a behavioural memory model.
module tb_dmem_responder;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  logic              CLK, RST, CEN, WEN, OEN, LD_EN, CLR;
  logic [ADDR_W-1:0] A, LD_A;
  logic [DATA_W-1:0] D, LD_D, Q;
  logic [CNT_W-1:0]  RD_CNT, WR_CNT;
  logic              ERR;
  logic [1:0]        ERR_CODE;

  dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D), .Q(Q),
    .LD_EN(LD_EN), .LD_A(LD_A), .LD_D(LD_D), .CLR(CLR),
    .RD_CNT(RD_CNT), .WR_CNT(WR_CNT), .ERR(ERR), .ERR_CODE(ERR_CODE)
  );

  typedef struct {
    logic [DATA_W-1:0] q;
    int                rd_cnt;
    int                wr_cnt;
    logic              err;
    int                code;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state
  logic [DATA_W-1:0] m_mem [DEPTH];
  int   m_rd, m_wr, m_code;
  logic m_err;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
    m_rd = 0; m_wr = 0; m_err = 1'b0; m_code = 0;
  endtask

  // One cycle: drive at the falling edge, record expectation, advance the model at the rising edge.
  task automatic cyc(input logic cen, input logic wen, input logic oen,
                     input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input logic ld, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ldd,
                     input logic clr, input logic rst_mid);
    exp_t e;
    bit is_rd, is_wr, is_cf, is_st;
    CEN = cen; WEN = wen; OEN = oen; A = a; D = d;
    LD_EN = ld; LD_A = la; LD_D = ldd; CLR = clr;
    is_rd = !cen && !oen && wen;
    is_wr = !cen && !wen && oen;
    is_cf = !cen && !wen && !oen;
    is_st = cen && (!wen || !oen);
    e.q = is_rd ? m_mem[a] : '0;
    e.rd_cnt = m_rd; e.wr_cnt = m_wr; e.err = m_err; e.code = m_code;
    exp_q.push_back(e);
    if (rst_mid) begin
      #4 RST = 1'b1;
    end
    @(posedge CLK);
    if (rst_mid) begin
      model_reset();
    end else begin
      if (is_wr) m_mem[a] = d;
      if (ld) m_mem[la] = ldd;
      if (clr) begin
        m_rd = 0; m_wr = 0; m_err = 1'b0; m_code = 0;
      end else begin
        if (is_rd) m_rd = (m_rd + 1 > CMAX) ? CMAX : m_rd + 1;
        if (is_wr) m_wr = (m_wr + 1 > CMAX) ? CMAX : m_wr + 1;
        if (!m_err && (is_cf || is_st)) begin
          m_err = 1'b1;
          m_code = is_cf ? 1 : 2;
        end
      end
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    cyc(1'b0, 1'b1, 1'b0, a, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cyc(1'b0, 1'b0, 1'b1, a, d, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b1, 1'b1, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input longint act, input longint expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the oldest pending expectation mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("Q", longint'(Q), longint'(e.q));
        check("RD_CNT", longint'(RD_CNT), longint'(e.rd_cnt));
        check("WR_CNT", longint'(WR_CNT), longint'(e.wr_cnt));
        check("ERR", longint'(ERR), longint'(e.err));
        check("ERR_CODE", longint'(ERR_CODE), longint'(e.code));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    logic [ADDR_W-1:0] a, la;
    RST = 1'b1; CEN = 1'b1; WEN = 1'b1; OEN = 1'b1; A = '0; D = '0;
    LD_EN = 1'b0; LD_A = '0; LD_D = '0; CLR = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Reset then read
    rd(7'd5);
    idle();
    // Write then read back, plus an unwritten word
    wr(7'h7F, 32'hDEADBEEF);
    rd(7'h7F);
    rd(7'h00);
    // Preload priority on same and different addresses
    cyc(1'b0, 1'b0, 1'b1, 7'd3, 32'h22, 1'b1, 7'd3, 32'h11, 1'b0, 1'b0);
    rd(7'd3);
    cyc(1'b0, 1'b0, 1'b1, 7'd4, 32'h22, 1'b1, 7'd3, 32'h11, 1'b0, 1'b0);
    rd(7'd3);
    rd(7'd4);
    // Conflict, then stray, then clear
    cyc(1'b0, 1'b0, 1'b0, 7'd2, 32'h55, 1'b0, '0, '0, 1'b0, 1'b0);
    rd(7'd2);
    cyc(1'b1, 1'b0, 1'b1, 7'd2, 32'h66, 1'b0, '0, '0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    idle();
    // Stray alone records code 10
    cyc(1'b1, 1'b1, 1'b0, 7'd1, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    // CLR coinciding with a write: write commits, counters cleared
    cyc(1'b0, 1'b0, 1'b1, 7'd6, 32'h1234, 1'b0, '0, '0, 1'b1, 1'b0);
    rd(7'd6);
    // Counter saturation
    for (int i = 0; i < 20; i++) rd(7'(i));
    for (int i = 0; i < 20; i++) wr(7'(i + 40), 32'(i * 3 + 1));
    // Reset mid-operation discards a pending write and clears memory
    wr(7'd9, 32'hA5A5A5A5);
    rd(7'd9);
    cyc(1'b0, 1'b0, 1'b1, 7'd10, 32'h5A5A5A5A, 1'b0, '0, '0, 1'b0, 1'b1);
    rd(7'd9);
    rd(7'd10);

    // Randomized traffic biased toward a small address window
    for (int n = 0; n < 3000; n++) begin
      op = int'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
      la = ($urandom_range(0, 1) == 0) ? a : 7'($urandom_range(0, 7));
      if (op <= 5)
        cyc(1'b0, 1'b1, 1'b0, a, $urandom, ($urandom_range(0, 5) == 0), la, $urandom,
            ($urandom_range(0, 19) == 0), 1'b0);
      else if (op <= 10)
        cyc(1'b0, 1'b0, 1'b1, a, $urandom, ($urandom_range(0, 5) == 0), la, $urandom,
            ($urandom_range(0, 19) == 0), 1'b0);
      else if (op == 11)
        cyc(1'b0, 1'b0, 1'b0, a, $urandom, 1'b0, la, $urandom, ($urandom_range(0, 3) == 0), 1'b0);
      else if (op == 12)
        cyc(1'b1, 1'($urandom), 1'b0, a, $urandom, 1'b0, la, $urandom,
            ($urandom_range(0, 3) == 0), 1'b0);
      else
        cyc(1'b1, 1'b1, 1'b1, a, $urandom, ($urandom_range(0, 3) == 0), la, $urandom,
            ($urandom_range(0, 9) == 0), 1'b0);
    end
    // Sweep the whole memory to compare every word against the model
    for (int i = 0; i < int'(DEPTH); i++) rd(7'(i));

    idle();
    #5;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
